// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: size codes, FSM states and helpers.
package mem_arbiter_pkg;

    localparam logic [2:0] SZ_NONE = 3'd0;
    localparam logic [2:0] SZ_BYTE = 3'd1;
    localparam logic [2:0] SZ_HALF = 3'd2;
    localparam logic [2:0] SZ_WORD = 3'd4;

    // Bytes in the attached data memory
    localparam int MEM_SIZE = 256;

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    function automatic logic size_legal(input logic [2:0] size);
        logic ok;
        case (size)
            SZ_BYTE, SZ_HALF, SZ_WORD: ok = 1'b1;
            default:                   ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            SZ_HALF: mis = addr_lo[0];
            SZ_WORD: mis = (addr_lo != 2'd0);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_arbiter_prio.sv
// Combinational grant decision between the fetch port (F) and the load/store port (D).
module arb_prio
    import mem_arbiter_pkg::*;
(
    input  logic       i_f_req,
    input  logic       i_d_req,
    input  arb_state_t i_state,
    input  logic       i_cnt_max,
    input  logic       i_d_size_ok,
    output logic       o_f_gnt,
    output logic       o_d_gnt
);

    logic d_ok_s;

    // A D request with an illegal size code is never eligible
    assign d_ok_s = i_d_req & i_d_size_ok;

    // D has priority unless F has starved long enough; while locked only D may win
    always_comb begin
        o_f_gnt = 1'b0;
        o_d_gnt = 1'b0;
        case (i_state)
            ARB_IDLE: begin
                if (i_f_req && i_cnt_max) begin
                    o_f_gnt = 1'b1;
                end else if (d_ok_s) begin
                    o_d_gnt = 1'b1;
                end else begin
                    o_f_gnt = i_f_req;
                end
            end
            ARB_LOCKED: begin
                o_d_gnt = d_ok_s;
            end
            default: begin
                o_f_gnt = 1'b0;
                o_d_gnt = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing the big-endian data memory between fetch (F) and load/store (D) ports.
// Optional misalignment detection on D is built when MEM_ARB_ALIGN_CHECK_EN is defined.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int ADDR_W     = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_f_req,
    input  logic [ADDR_W-1:0] i_f_addr,
    output logic              o_f_gnt,
    output logic              o_f_rvalid,
    output logic [31:0]       o_f_rdata,
    input  logic              i_d_req,
    input  logic              i_d_we,
    input  logic [ADDR_W-1:0] i_d_addr,
    input  logic [2:0]        i_d_size,
    input  logic              i_d_sign,
    input  logic [31:0]       i_d_wdata,
    input  logic              i_d_lock,
    output logic              o_d_gnt,
    output logic              o_d_rvalid,
    output logic [31:0]       o_d_rdata,
    output logic [ADDR_W-1:0] o_m_addr,
    output logic [2:0]        o_m_insize,
    output logic              o_m_insign,
    output logic [2:0]        o_m_outsize,
    output logic [31:0]       o_m_data,
    input  logic [31:0]       i_m_data
`ifdef MEM_ARB_ALIGN_CHECK_EN
    ,
    output logic              o_d_misalign
`endif
);

    localparam logic [3:0] STARVE_MAX_C = 4'(STARVE_MAX);

    arb_state_t  state_r;
    logic [3:0]  starve_r;
    logic        cnt_max_s;
    logic        f_gnt_s;
    logic        d_gnt_s;
    logic        d_mis_s;
    logic        f_rvalid_r;
    logic        d_rvalid_r;
    logic [31:0] f_rdata_r;
    logic [31:0] d_rdata_r;

    assign cnt_max_s = (starve_r == STARVE_MAX_C);

    arb_prio u_prio (
        .i_f_req     (i_f_req),
        .i_d_req     (i_d_req),
        .i_state     (state_r),
        .i_cnt_max   (cnt_max_s),
        .i_d_size_ok (size_legal(i_d_size)),
        .o_f_gnt     (f_gnt_s),
        .o_d_gnt     (d_gnt_s)
    );

    // Grants are suppressed while reset is held so no store can commit at that edge
    assign o_f_gnt = f_gnt_s & i_rst_n;
    assign o_d_gnt = d_gnt_s & i_rst_n;

`ifdef MEM_ARB_ALIGN_CHECK_EN
    logic d_misalign_r;

    assign d_mis_s      = is_misaligned(i_d_size, i_d_addr[1:0]);
    assign o_d_misalign = d_misalign_r;

    // One-cycle flag following a misaligned D grant
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            d_misalign_r <= 1'b0;
        end else begin
            d_misalign_r <= o_d_gnt & d_mis_s;
        end
    end
`else
    assign d_mis_s = 1'b0;
`endif

    // Memory is driven from the granted port in the grant cycle; idle drive is all zero
    always_comb begin
        o_m_addr    = '0;
        o_m_insize  = SZ_NONE;
        o_m_insign  = 1'b0;
        o_m_outsize = SZ_NONE;
        o_m_data    = 32'd0;
        if (o_d_gnt && !d_mis_s) begin
            o_m_addr = i_d_addr;
            if (i_d_we) begin
                o_m_outsize = i_d_size;
                o_m_data    = i_d_wdata;
            end else begin
                o_m_insize = i_d_size;
                o_m_insign = i_d_sign;
            end
        end else if (o_f_gnt) begin
            o_m_addr   = i_f_addr;
            o_m_insize = SZ_WORD;
        end else begin
            o_m_addr = '0;
        end
    end

    // Arbitration state, starvation counter and returned read data
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r    <= ARB_IDLE;
            starve_r   <= 4'd0;
            f_rvalid_r <= 1'b0;
            d_rvalid_r <= 1'b0;
            f_rdata_r  <= 32'd0;
            d_rdata_r  <= 32'd0;
        end else begin
            f_rvalid_r <= o_f_gnt;
            if (o_f_gnt) begin
                f_rdata_r <= i_m_data;
            end
            d_rvalid_r <= o_d_gnt & (~i_d_we | d_mis_s);
            if (o_d_gnt && d_mis_s) begin
                d_rdata_r <= 32'd0;
            end else if (o_d_gnt && !i_d_we) begin
                d_rdata_r <= i_m_data;
            end
            if (!i_f_req || o_f_gnt) begin
                starve_r <= 4'd0;
            end else if (!cnt_max_s) begin
                starve_r <= starve_r + 4'd1;
            end
            case (state_r)
                ARB_IDLE: begin
                    if (o_d_gnt && i_d_lock) begin
                        state_r <= ARB_LOCKED;
                    end
                end
                ARB_LOCKED: begin
                    if (!i_d_req || (o_d_gnt && !i_d_lock)) begin
                        state_r <= ARB_IDLE;
                    end
                end
                default: state_r <= ARB_IDLE;
            endcase
        end
    end

    assign o_f_rvalid = f_rvalid_r;
    assign o_d_rvalid = d_rvalid_r;
    assign o_f_rdata  = f_rdata_r;
    assign o_d_rdata  = d_rdata_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a big-endian byte memory model and read-data scoreboard.
`timescale 1ns/1ps
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int ADDR_W     = 32;
    localparam int STARVE_MAX = 4;

    logic              i_clk = 1'b0;
    logic              i_rst_n;
    logic              i_f_req;
    logic [ADDR_W-1:0] i_f_addr;
    logic              o_f_gnt;
    logic              o_f_rvalid;
    logic [31:0]       o_f_rdata;
    logic              i_d_req;
    logic              i_d_we;
    logic [ADDR_W-1:0] i_d_addr;
    logic [2:0]        i_d_size;
    logic              i_d_sign;
    logic [31:0]       i_d_wdata;
    logic              i_d_lock;
    logic              o_d_gnt;
    logic              o_d_rvalid;
    logic [31:0]       o_d_rdata;
    logic [ADDR_W-1:0] o_m_addr;
    logic [2:0]        o_m_insize;
    logic              o_m_insign;
    logic [2:0]        o_m_outsize;
    logic [31:0]       o_m_data;
    logic [31:0]       i_m_data;
`ifdef MEM_ARB_ALIGN_CHECK_EN
    logic              o_d_misalign;
`endif

    mem_arbiter #(.STARVE_MAX(STARVE_MAX), .ADDR_W(ADDR_W)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_f_req     (i_f_req),
        .i_f_addr    (i_f_addr),
        .o_f_gnt     (o_f_gnt),
        .o_f_rvalid  (o_f_rvalid),
        .o_f_rdata   (o_f_rdata),
        .i_d_req     (i_d_req),
        .i_d_we      (i_d_we),
        .i_d_addr    (i_d_addr),
        .i_d_size    (i_d_size),
        .i_d_sign    (i_d_sign),
        .i_d_wdata   (i_d_wdata),
        .i_d_lock    (i_d_lock),
        .o_d_gnt     (o_d_gnt),
        .o_d_rvalid  (o_d_rvalid),
        .o_d_rdata   (o_d_rdata),
        .o_m_addr    (o_m_addr),
        .o_m_insize  (o_m_insize),
        .o_m_insign  (o_m_insign),
        .o_m_outsize (o_m_outsize),
        .o_m_data    (o_m_data),
        .i_m_data    (i_m_data)
`ifdef MEM_ARB_ALIGN_CHECK_EN
        ,
        .o_d_misalign(o_d_misalign)
`endif
    );

    always #5 i_clk = ~i_clk;

    int          err_cnt = 0;
    int          chk_cnt = 0;
    logic [31:0] f_q[$];
    logic [31:0] d_q[$];
    logic        f_pend = 1'b0;
    logic        d_pend = 1'b0;
    logic        mem_load = 1'b1;
    logic [7:0]  mem_r [MEM_SIZE];
    logic [7:0]  ma_s;

    function automatic logic [7:0] pat(input int a);
        return 8'((a * 7) + 53);
    endfunction

    function automatic logic [31:0] pat_word(input int a);
        return {pat(a), pat(a + 1), pat(a + 2), pat(a + 3)};
    endfunction

    // Memory model: combinational big-endian read, write at the rising edge
    assign ma_s = o_m_addr[7:0];

    always_comb begin
        i_m_data = 32'd0;
        case (o_m_insize)
            3'd1: i_m_data = {{24{o_m_insign & mem_r[ma_s][7]}}, mem_r[ma_s]};
            3'd2: i_m_data = {{16{o_m_insign & mem_r[ma_s][7]}}, mem_r[ma_s], mem_r[ma_s + 8'd1]};
            3'd4: i_m_data = {mem_r[ma_s], mem_r[ma_s + 8'd1], mem_r[ma_s + 8'd2], mem_r[ma_s + 8'd3]};
            default: i_m_data = 32'd0;
        endcase
    end

    always @(posedge i_clk) begin
        if (mem_load) begin
            for (int i = 0; i < MEM_SIZE; i++) mem_r[i] <= pat(i);
        end else begin
            case (o_m_outsize)
                3'd1: mem_r[ma_s] <= o_m_data[7:0];
                3'd2: begin
                    mem_r[ma_s]        <= o_m_data[15:8];
                    mem_r[ma_s + 8'd1] <= o_m_data[7:0];
                end
                3'd4: begin
                    mem_r[ma_s]        <= o_m_data[31:24];
                    mem_r[ma_s + 8'd1] <= o_m_data[23:16];
                    mem_r[ma_s + 8'd2] <= o_m_data[15:8];
                    mem_r[ma_s + 8'd3] <= o_m_data[7:0];
                end
                default: ;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One clock: score returned data, check grants, queue expected read data
    task automatic step(input logic ef, input logic ed, input logic dpush, input logic [31:0] dexp);
        @(negedge i_clk);
        check("f_rvalid", 32'(o_f_rvalid), 32'(f_pend));
        check("d_rvalid", 32'(o_d_rvalid), 32'(d_pend));
        if (o_f_rvalid && f_q.size() > 0) check("f_rdata", o_f_rdata, f_q.pop_front());
        if (o_d_rvalid && d_q.size() > 0) check("d_rdata", o_d_rdata, d_q.pop_front());
        check("f_gnt", 32'(o_f_gnt), 32'(ef));
        check("d_gnt", 32'(o_d_gnt), 32'(ed));
        check("gnt_excl", 32'(o_f_gnt & o_d_gnt), 32'd0);
        if (!o_f_gnt && !o_d_gnt) begin
            check("m_insize_idle", 32'(o_m_insize), 32'd0);
            check("m_outsize_idle", 32'(o_m_outsize), 32'd0);
        end
        if (o_f_gnt) f_q.push_back(pat_word(int'(i_f_addr[7:0])));
        if (o_d_gnt && dpush) d_q.push_back(dexp);
        f_pend = o_f_gnt;
        d_pend = o_d_gnt & dpush;
        @(posedge i_clk);
        #1;
    endtask

    task automatic d_set(input logic req, input logic we, input logic [31:0] addr,
                         input logic [2:0] size, input logic sign, input logic [31:0] wdata,
                         input logic lock);
        i_d_req   = req;
        i_d_we    = we;
        i_d_addr  = addr;
        i_d_size  = size;
        i_d_sign  = sign;
        i_d_wdata = wdata;
        i_d_lock  = lock;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst_n  = 1'b0;
        i_f_req  = 1'b0;
        i_f_addr = 32'd0;
        d_set(1'b0, 1'b0, 32'd0, 3'd0, 1'b0, 32'd0, 1'b0);
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_f_rvalid", 32'(o_f_rvalid), 32'd0);
        check("rst_d_rvalid", 32'(o_d_rvalid), 32'd0);
        check("rst_f_rdata", o_f_rdata, 32'd0);
        check("rst_d_rdata", o_d_rdata, 32'd0);
        check("rst_m_addr", o_m_addr, 32'd0);
`ifdef MEM_ARB_ALIGN_CHECK_EN
        check("rst_misalign", 32'(o_d_misalign), 32'd0);
`endif
        mem_load = 1'b0;
        i_rst_n  = 1'b1;

        // Store then loads of various sizes and signedness
        d_set(1'b1, 1'b1, 32'h10, 3'd4, 1'b0, 32'hDEADBEEF, 1'b0);
        step(1'b0, 1'b1, 1'b0, 32'd0);
        check("st_mem", {mem_r[16], mem_r[17], mem_r[18], mem_r[19]}, 32'hDEADBEEF);
        d_set(1'b1, 1'b0, 32'h10, 3'd2, 1'b1, 32'd0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 32'hFFFFDEAD);
        d_set(1'b1, 1'b0, 32'h11, 3'd1, 1'b1, 32'd0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 32'hFFFFFFAD);
        d_set(1'b1, 1'b0, 32'h12, 3'd2, 1'b0, 32'd0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 32'h0000BEEF);
        d_set(1'b0, 1'b0, 32'd0, 3'd0, 1'b0, 32'd0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'd0);

        // Continuous contention: D wins STARVE_MAX times, then F
        i_f_req  = 1'b1;
        i_f_addr = 32'h40;
        d_set(1'b1, 1'b0, 32'h10, 3'd4, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step((i % 5) == 4, (i % 5) != 4, 1'b1, 32'hDEADBEEF);
            if ((i % 5) == 4) i_f_addr = i_f_addr + 32'd4;
        end

        // Lock keeps F out even once its counter is saturated
        i_f_req = 1'b0;
        d_set(1'b0, 1'b0, 32'd0, 3'd0, 1'b0, 32'd0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        i_f_req  = 1'b1;
        i_f_addr = 32'h50;
        d_set(1'b1, 1'b0, 32'h10, 3'd1, 1'b0, 32'd0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 32'h000000DE);
        i_d_lock = 1'b0;
        step(1'b0, 1'b1, 1'b1, 32'h000000DE);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        i_f_addr = 32'h54;
        step(1'b0, 1'b1, 1'b1, 32'h000000DE);

        // Lock dropped by withdrawing the D request
        i_f_req  = 1'b0;
        i_d_lock = 1'b1;
        step(1'b0, 1'b1, 1'b1, 32'h000000DE);
        i_f_req = 1'b1;
        i_d_req = 1'b0;
        step(1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'd0);

        // Illegal size codes stall D without touching memory
        i_f_addr = 32'h58;
        d_set(1'b1, 1'b0, 32'h10, 3'd3, 1'b0, 32'd0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        i_f_req = 1'b0;
        d_set(1'b1, 1'b1, 32'h30, 3'd3, 1'b0, 32'hCAFEF00D, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        i_d_size = 3'd0;
        step(1'b0, 1'b0, 1'b0, 32'd0);
        check("illegal_mem", 32'(mem_r[8'h30]), 32'(pat(8'h30)));
        i_d_size = 3'd1;
        step(1'b0, 1'b1, 1'b0, 32'd0);
        check("byte_store_mem", 32'(mem_r[8'h30]), 32'h0000000D);

        // Reset mid-cycle after a locked load grant
        d_set(1'b1, 1'b0, 32'h10, 3'd4, 1'b0, 32'd0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 32'hDEADBEEF);
        check("pre_rst_rvalid", 32'(o_d_rvalid), 32'd1);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("rst_mid_d_rvalid", 32'(o_d_rvalid), 32'd0);
        check("rst_mid_d_rdata", o_d_rdata, 32'd0);
        check("rst_mid_f_rdata", o_f_rdata, 32'd0);
        d_q.delete();
        f_q.delete();
        d_pend = 1'b0;
        f_pend = 1'b0;
        d_set(1'b1, 1'b1, 32'h20, 3'd4, 1'b0, 32'h11223344, 1'b0);
        @(posedge i_clk);
        #1;
        check("rst_no_store", 32'(mem_r[8'h20]), 32'(pat(8'h20)));
        check("rst_hold_rvalid", 32'(o_d_rvalid), 32'd0);
        d_set(1'b0, 1'b0, 32'd0, 3'd0, 1'b0, 32'd0, 1'b0);
        i_f_req  = 1'b1;
        i_f_addr = 32'h60;
        i_rst_n  = 1'b1;
        step(1'b1, 1'b0, 1'b0, 32'd0);
        i_f_req = 1'b0;
        step(1'b0, 1'b0, 1'b0, 32'd0);

`ifdef MEM_ARB_ALIGN_CHECK_EN
        // Misaligned D accesses are granted, not driven, and flagged
        d_set(1'b1, 1'b1, 32'h13, 3'd4, 1'b0, 32'h01020304, 1'b0);
        step(1'b0, 1'b1, 1'b1, 32'd0);
        check("mis_flag", 32'(o_d_misalign), 32'd1);
        check("mis_mem0", 32'(mem_r[8'h13]), 32'h000000EF);
        check("mis_mem1", 32'(mem_r[8'h14]), 32'(pat(8'h14)));
        d_set(1'b1, 1'b0, 32'h11, 3'd2, 1'b1, 32'd0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 32'd0);
        d_set(1'b0, 1'b0, 32'd0, 3'd0, 1'b0, 32'd0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        check("mis_clear", 32'(o_d_misalign), 32'd0);
`endif

        step(1'b0, 1'b0, 1'b0, 32'd0);
        check("f_q_drained", 32'(f_q.size()), 32'd0);
        check("d_q_drained", 32'(d_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
